// File: rtl/bin2bcd_seq_if.sv
//------------------------------------------------------------------------------
// bin2bcd_seq_if : handshake bundle for the binary-to-BCD converter
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface bin2bcd_seq_if #(
  parameter int WIDTH   = 8,
  parameter int NDIGITS = 6
);
  localparam int N   = 2 * WIDTH + 1;
  localparam int NDW = $clog2(NDIGITS + 1);

  logic                   valid_i;
  logic                   ready_o;
  logic [N-1:0]           bin_i;
  logic                   valid_o;
  logic                   ready_i;
  logic [4*NDIGITS-1:0]   bcd_o;
  logic [NDW-1:0]         ndig_o;

  modport slave (
    input  valid_i, bin_i, ready_i,
    output ready_o, valid_o, bcd_o, ndig_o
  );

  modport master (
    output valid_i, bin_i, ready_i,
    input  ready_o, valid_o, bcd_o, ndig_o
  );
endinterface

`default_nettype wire

// File: rtl/bin2bcd_seq.sv
//------------------------------------------------------------------------------
// bin2bcd_seq : sequential double-dabble converter, one bit per clock
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module bin2bcd_seq #(
  parameter int WIDTH   = 8,
  parameter int NDIGITS = 6
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  bin2bcd_seq_if.slave  bus
);
  localparam int N   = 2 * WIDTH + 1;
  localparam int BW  = 4 * NDIGITS;
  localparam int CW  = $clog2(N + 1);
  localparam int NDW = $clog2(NDIGITS + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N-1:0]    bin_q, bin_d;
  logic [BW-1:0]   bcd_q, bcd_d;
  logic [BW-1:0]   res_q, res_d;
  logic [NDW-1:0]  ndig_q, ndig_d;

  logic [BW-1:0]   corr_w;
  logic [BW+N-1:0] shift_w;
  logic [NDW-1:0]  ndig_w;

  // Add-3 correction on every digit from the pre-shift value, then one joint shift
  always_comb begin
    corr_w = '0;
    for (int i = 0; i < NDIGITS; i++) begin
      corr_w[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3
                                                   : bcd_q[4*i +: 4];
    end
    shift_w = {corr_w, bin_q} << 1;
    ndig_w  = NDW'(1);
    for (int i = 0; i < NDIGITS; i++) begin
      if (shift_w[N + 4*i +: 4] != 4'd0) ndig_w = NDW'(i + 1);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    res_d   = res_q;
    ndig_d  = ndig_q;
    case (state_q)
      S_IDLE: begin
        if (bus.valid_i) begin
          bin_d   = bus.bin_i;
          bcd_d   = '0;
          cnt_d   = CW'(N);
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        bin_d = shift_w[N-1:0];
        bcd_d = shift_w[BW+N-1:N];
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          res_d   = shift_w[BW+N-1:N];
          ndig_d  = ndig_w;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bin_q   <= '0;
      bcd_q   <= '0;
      res_q   <= '0;
      ndig_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      res_q   <= res_d;
      ndig_q  <= ndig_d;
    end
  end

  assign bus.ready_o = (state_q == S_IDLE);
  assign bus.valid_o = (state_q == S_DONE);
  assign bus.bcd_o   = res_q;
  assign bus.ndig_o  = ndig_q;

endmodule

`default_nettype wire

// File: tb/tb_bin2bcd_seq.sv
//------------------------------------------------------------------------------
// tb_bin2bcd_seq : directed plus random conversions against a decimal model
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_bin2bcd_seq;
  localparam int WIDTH   = 8;
  localparam int NDIGITS = 6;
  localparam int N       = 2 * WIDTH + 1;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  int   tests  = 0;
  int   fails  = 0;

  bin2bcd_seq_if #(.WIDTH(WIDTH), .NDIGITS(NDIGITS)) bus ();

  bin2bcd_seq #(.WIDTH(WIDTH), .NDIGITS(NDIGITS)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [23:0] ref_bcd(input int unsigned v);
    logic [23:0] r;
    int unsigned t;
    t = v;
    r = '0;
    for (int i = 0; i < NDIGITS; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic int ref_ndig(input int unsigned v);
    int n;
    int unsigned t;
    n = 1;
    t = v;
    while (t >= 10) begin
      t = t / 10;
      n++;
    end
    return n;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // One full transaction: accept, N shift edges, optional DONE stall, consume
  task automatic conv(input int unsigned v, input bit scramble, input int hold);
    logic [23:0] prev;
    logic [23:0] res;
    logic [2:0]  nd;
    bit          early;
    bit          moved;
    int          g;
    prev = bus.bcd_o;
    g = 0;
    while (!bus.ready_o && g < 100) begin
      tick();
      g++;
    end
    check("ready_before_accept", 32'(bus.ready_o), 32'd1);
    bus.valid_i = 1'b1;
    bus.bin_i   = N'(v);
    tick();
    if (!scramble) bus.valid_i = 1'b0;
    early = 1'b0;
    for (int k = 1; k <= N; k++) begin
      if (scramble) begin
        bus.valid_i = 1'b1;
        bus.bin_i   = N'($urandom);
      end
      tick();
      if (k == 1) begin
        check("bcd_held_in_shift", 32'(bus.bcd_o), 32'(prev));
        check("ready_low_in_shift", 32'(bus.ready_o), 32'd0);
      end
      if (k < N && bus.valid_o) early = 1'b1;
    end
    bus.valid_i = 1'b0;
    check("valid_early", 32'(early), 32'd0);
    check("valid_latency", 32'(bus.valid_o), 32'd1);
    check("bcd_value", 32'(bus.bcd_o), 32'(ref_bcd(v)));
    check("ndig_value", 32'(bus.ndig_o), 32'(ref_ndig(v)));
    res   = bus.bcd_o;
    nd    = bus.ndig_o;
    moved = 1'b0;
    for (int k = 0; k < hold; k++) begin
      tick();
      if (!bus.valid_o || bus.ready_o || bus.bcd_o !== res || bus.ndig_o !== nd) moved = 1'b1;
    end
    if (hold > 0) check("done_hold_stable", 32'(moved), 32'd0);
    bus.ready_i = 1'b1;
    tick();
    bus.ready_i = 1'b0;
    check("ready_after_consume", 32'(bus.ready_o), 32'd1);
    check("valid_after_consume", 32'(bus.valid_o), 32'd0);
    check("bcd_kept_in_idle", 32'(bus.bcd_o), 32'(ref_bcd(v)));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw_valid;
    int unsigned v;
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b0;
    bus.bin_i   = '0;
    rst_ni      = 1'b0;
    repeat (3) tick();
    rst_ni = 1'b1;
    check("rst_ready", 32'(bus.ready_o), 32'd1);
    check("rst_valid", 32'(bus.valid_o), 32'd0);
    check("rst_bcd", 32'(bus.bcd_o), 32'd0);
    check("rst_ndig", 32'(bus.ndig_o), 32'd0);

    conv(0, 1'b0, 0);
    conv(65025, 1'b0, 0);
    conv(131071, 1'b0, 0);
    conv(7, 1'b0, 10);
    conv(999, 1'b1, 0);
    conv(100000, 1'b0, 0);
    conv(10, 1'b0, 2);

    // Reset lands on the 8th shift edge of 12345
    bus.valid_i = 1'b1;
    bus.bin_i   = N'(12345);
    tick();
    bus.valid_i = 1'b0;
    repeat (7) tick();
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    check("midrst_ready", 32'(bus.ready_o), 32'd1);
    check("midrst_valid", 32'(bus.valid_o), 32'd0);
    check("midrst_bcd", 32'(bus.bcd_o), 32'd0);
    check("midrst_ndig", 32'(bus.ndig_o), 32'd0);
    saw_valid = 1'b0;
    for (int k = 0; k < N + 5; k++) begin
      tick();
      if (bus.valid_o) saw_valid = 1'b1;
    end
    check("midrst_no_valid", 32'(saw_valid), 32'd0);
    conv(42, 1'b0, 0);

    for (int r = 0; r < 40; r++) begin
      v = $urandom_range(131071, 0);
      conv(v, r[0], int'($urandom_range(3, 0)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Sequential binary-to-BCD converter placed directly downstream of the n-bit multiplier: it accepts the (2·width+1)-bit product and converts it, one bit per clock using shift-and-add-3 (double dabble), into packed BCD digits for the display/formatting stage. A valid/ready handshake on both sides decouples the combinational arithmetic path from the display logic. The block also reports the count of significant digits, which the display uses for leading-zero blanking.

## Interface
- width, 8, operand width of the upstream multiplier; binary input is 2·width+1 bits (N = 2·width+1).
- ndigits, 6, BCD digits produced; must satisfy 10^ndigits > 2^N (6 for width=8).
- clk_i  in  1  clock, all state updates on rising edge.
- rst_ni  in  1  reset; one clock; reset is synchronous and active-low.
- valid_i  in  1  bin_i holds a value to convert.
- ready_o  out  1  block can accept a value (high only in IDLE).
- bin_i  in  N  unsigned binary value (multiplier s_o).
- valid_o  out  1  bcd_o/ndig_o hold a completed result.
- ready_i  in  1  downstream consumes the result.
- bcd_o  out  4·ndigits  packed BCD, digit 0 (units) in bits [3:0].
- ndig_o  out  ceil(log2(ndigits+1))  number of significant digits, 1..ndigits (value 0 counts as 1 digit).

## Operation
- States: IDLE, SHIFT, DONE. Reset (rst_ni low at a rising edge) forces IDLE, clears bit counter, binary shift register, BCD shift register; bcd_o=0, ndig_o=0, valid_o=0, ready_o=1 after that edge.
- IDLE: ready_o=1, valid_o=0. On edge with valid_i=1: capture bin_i into binary shift register, clear BCD shift register, load counter with N, go to SHIFT. valid_i=0: stay.
- SHIFT: ready_o=0, valid_o=0. Each edge: every BCD digit ≥5 gets +3 (all digits corrected in parallel from the pre-shift value), then {BCD, binary} shifted left by one, binary MSB entering BCD bit 0; counter decrements. On the edge performing the N-th shift: load bcd_o with the final BCD value, load ndig_o, go to DONE.
- ndig_o = 1 + index of the most significant nonzero digit of the final value; 1 when value is 0.
- DONE: valid_o=1, bcd_o/ndig_o stable. On edge with ready_i=1: go to IDLE. ready_i=0: hold indefinitely.
- bcd_o/ndig_o are dedicated output registers: they keep the last result through IDLE and the next SHIFT, change only on the SHIFT→DONE edge or reset.
- valid_i and bin_i are ignored outside IDLE; bin_i need not stay stable after acceptance.
- No overflow path: parameter constraint guarantees every N-bit value fits; every digit of bcd_o is always 0..9.

## Timing
- Acceptance at edge A (valid_i & ready_o). SHIFT occupies edges A+1..A+N; valid_o rises after edge A+N (N cycles of latency; 17 for width=8).
- Consume at edge C (valid_o & ready_i); ready_o high from edge C+1's cycle, i.e. IDLE in the cycle after C; next acceptance earliest at edge C+1. Minimum issue interval N+2 cycles.
- valid_o is a level held until consumed, not a pulse; drops in the cycle after edge C.
- Reset asserted mid-SHIFT or in DONE: abandons the conversion, no valid_o produced, all outputs at reset values after that edge.
- All outputs registered; no combinational path from any input to any output.

## Test plan
- Reset, then bin_i=0 with valid_i pulse (width=8) -> valid_o exactly 17 cycles after acceptance, bcd_o=0x000000, ndig_o=1.
- bin_i=65025 (255·255) -> bcd_o=0x065025, ndig_o=5; bin_i=131071 (max 17-bit) -> bcd_o=0x131071, ndig_o=6.
- Sweep of all 2^17 inputs with ready_i=1 -> every bcd_o equals reference decimal, every nibble ≤9, ndig_o correct.
- ready_i held low 10 cycles in DONE -> valid_o, bcd_o, ndig_o constant, ready_o=0; ready_i high -> ready_o=1 next cycle.
- valid_i=1 with bin_i changing every cycle during SHIFT -> ignored; result matches value captured at acceptance (e.g. 999 -> 0x000999, ndig_o=3).
- rst_ni low for one edge at shift 8 of a conversion of 12345 -> valid_o never rises, bcd_o=0, ndig_o=0, ready_o=1 next cycle; new conversion of 42 afterwards -> 0x000042, ndig_o=2.
